// File: rtl/axi_rd_resp_buffer_if.sv
// Read-response bundle between the AXI shim read channel, the response buffer and its consumer.
// The slave modport is the buffer's view; master is the shim/consumer side.
interface axi_rd_resp_buffer_if #(
   parameter int DataWidth = 64,
   parameter int UserWidth = 64,
   parameter int IdWidth   = 4,
   parameter int Depth     = 4
);
   localparam int UsageWidth = $clog2(Depth) + 1;

   logic                  shim_valid_i;
   logic [DataWidth-1:0]  shim_data_i;
   logic [UserWidth-1:0]  shim_user_i;
   logic                  shim_last_i;
   logic [IdWidth-1:0]    shim_id_i;
   logic                  shim_exokay_i;
   logic                  shim_rdy_o;

   logic                  valid_o;
   logic [DataWidth-1:0]  data_o;
   logic [UserWidth-1:0]  user_o;
   logic                  last_o;
   logic [IdWidth-1:0]    id_o;
   logic                  exokay_o;
   logic                  rdy_i;
   logic [UsageWidth-1:0] usage_o;
   logic [7:0]            beat_idx_o;

   modport slave (
      input  shim_valid_i, shim_data_i, shim_user_i, shim_last_i, shim_id_i, shim_exokay_i,
      input  rdy_i,
      output shim_rdy_o, valid_o, data_o, user_o, last_o, id_o, exokay_o, usage_o, beat_idx_o
   );

   modport master (
      output shim_valid_i, shim_data_i, shim_user_i, shim_last_i, shim_id_i, shim_exokay_i,
      output rdy_i,
      input  shim_rdy_o, valid_o, data_o, user_o, last_o, id_o, exokay_o, usage_o, beat_idx_o
   );
endinterface

// File: rtl/axi_rd_resp_buffer.sv
// Circular FIFO buffering AXI read beats between the shim and the consumer, with per-burst beat index.
// Define AXI_RD_RESP_BUFFER_FALLTHROUGH_EN to present an input beat combinationally when the buffer is empty.
module axi_rd_resp_buffer #(
   parameter int DataWidth = 64,
   parameter int UserWidth = 64,
   parameter int IdWidth   = 4,
   parameter int Depth     = 4
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   axi_rd_resp_buffer_if.slave bus
);
   localparam int PtrWidth = $clog2(Depth);
   localparam int CntWidth = PtrWidth + 1;
   localparam logic [CntWidth-1:0] FullCnt = CntWidth'(Depth);

   logic [DataWidth-1:0] mem_data   [Depth];
   logic [UserWidth-1:0] mem_user   [Depth];
   logic                 mem_last   [Depth];
   logic [IdWidth-1:0]   mem_id     [Depth];
   logic                 mem_exokay [Depth];

   logic [PtrWidth-1:0]  wr_ptr, rd_ptr;
   logic [CntWidth-1:0]  usage;
   logic [7:0]           beat_idx;
   logic                 empty, full, push, pop, consume, head_vld;

   logic [DataWidth-1:0] head_data;
   logic [UserWidth-1:0] head_user;
   logic                 head_last;
   logic [IdWidth-1:0]   head_id;
   logic                 head_exokay;

   assign empty = (usage == '0);
   assign full  = (usage == FullCnt);

`ifdef AXI_RD_RESP_BUFFER_FALLTHROUGH_EN
   logic bypass;
   assign bypass   = empty && bus.shim_valid_i;
   assign head_vld = rst_ni && (!empty || bus.shim_valid_i);
   // A bypassed beat taken by the consumer in the same cycle is never written
   assign push     = bus.shim_valid_i && !full && !(bypass && bus.rdy_i);

   always_comb begin
      head_data   = mem_data[rd_ptr];
      head_user   = mem_user[rd_ptr];
      head_last   = mem_last[rd_ptr];
      head_id     = mem_id[rd_ptr];
      head_exokay = mem_exokay[rd_ptr];
      if (bypass) begin
         head_data   = bus.shim_data_i;
         head_user   = bus.shim_user_i;
         head_last   = bus.shim_last_i;
         head_id     = bus.shim_id_i;
         head_exokay = bus.shim_exokay_i;
      end
   end
`else
   assign head_vld    = rst_ni && !empty;
   assign push        = bus.shim_valid_i && !full;
   assign head_data   = mem_data[rd_ptr];
   assign head_user   = mem_user[rd_ptr];
   assign head_last   = mem_last[rd_ptr];
   assign head_id     = mem_id[rd_ptr];
   assign head_exokay = mem_exokay[rd_ptr];
`endif

   assign consume = head_vld && bus.rdy_i;
   assign pop     = consume && !empty;

   // Storage is deliberately left out of reset; outputs are gated instead
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_data[wr_ptr]   <= bus.shim_data_i;
         mem_user[wr_ptr]   <= bus.shim_user_i;
         mem_last[wr_ptr]   <= bus.shim_last_i;
         mem_id[wr_ptr]     <= bus.shim_id_i;
         mem_exokay[wr_ptr] <= bus.shim_exokay_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         usage    <= '0;
         beat_idx <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   usage <= usage + 1'b1;
            2'b01:   usage <= usage - 1'b1;
            default: usage <= usage;
         endcase
         if (consume) beat_idx <= head_last ? 8'd0 : beat_idx + 8'd1;
      end
   end

   assign bus.shim_rdy_o = !full;
   assign bus.valid_o    = head_vld;
   assign bus.data_o     = rst_ni ? head_data   : '0;
   assign bus.user_o     = rst_ni ? head_user   : '0;
   assign bus.last_o     = rst_ni ? head_last   : 1'b0;
   assign bus.id_o       = rst_ni ? head_id     : '0;
   assign bus.exokay_o   = rst_ni ? head_exokay : 1'b0;
   assign bus.usage_o    = usage;
   assign bus.beat_idx_o = beat_idx;
endmodule

// File: doc/axi_rd_resp_buffer.md
AXI_RD_RESP_BUFFER -- requirements
Module: axi_rd_resp_buffer

Interface
REQ-001 SHALL have parameter DataWidth, default 64, width of read data beat.
REQ-002 SHALL have parameter UserWidth, default 64, width of read user field.
REQ-003 SHALL have parameter IdWidth, default 4, width of transaction ID.
REQ-004 SHALL have parameter Depth, default 4, number of buffer entries; legal values are powers of two, minimum 2.
REQ-005 SHALL have one clock and one reset: clk_i  in  1  clock, all logic on rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 shim_valid_i  in  1  read beat valid from the AXI shim read channel.
REQ-008 shim_data_i  in  DataWidth  read beat data.
REQ-009 shim_user_i  in  UserWidth  read beat user bits.
REQ-010 shim_last_i  in  1  last beat of the burst.
REQ-011 shim_id_i  in  IdWidth  transaction ID.
REQ-012 shim_exokay_i  in  1  exclusive-okay response.
REQ-013 shim_rdy_o  out  1  ready to the shim; drives the shim read-ready input.
REQ-014 valid_o  out  1  beat available to the consumer.
REQ-015 data_o, user_o, last_o, id_o, exokay_o  out  DataWidth/UserWidth/1/IdWidth/1  head-of-buffer beat fields.
REQ-016 rdy_i  in  1  consumer accepts the beat.
REQ-017 usage_o  out  $clog2(Depth)+1  number of occupied entries.
REQ-018 beat_idx_o  out  8  index of the presented beat within its burst.

Function
REQ-019 Push SHALL occur when shim_valid_i && shim_rdy_o; pop SHALL occur when valid_o && rdy_i.
REQ-020 shim_rdy_o SHALL equal (usage_o != Depth); there is no pass-through when full, even if a pop occurs in the same cycle.
REQ-021 Storage SHALL be a circular FIFO with read and write pointers of $clog2(Depth) bits that wrap from Depth-1 to 0.
REQ-022 On a simultaneous push and pop, usage_o SHALL remain unchanged and both pointers SHALL advance.
REQ-023 valid_o SHALL equal (usage_o != 0), except as modified by REQ-031.
REQ-024 All output fields SHALL reflect the head entry.
REQ-025 Beat order SHALL be preserved exactly; IDs SHALL NOT be reordered.
REQ-026 beat_idx_o SHALL be 0 for the first beat of each burst.
REQ-027 beat_idx_o SHALL increment by 1 on each pop with last_o=0, wrapping from 255 to 0.
REQ-028 beat_idx_o SHALL return to 0 on the pop of a beat with last_o=1.
REQ-029 With an empty buffer, a pushed beat SHALL appear on valid_o in the following cycle (1-cycle latency).
REQ-030 Data path outputs SHALL hold stable while valid_o=1 and rdy_i=0.

Reset
REQ-031 While rst_ni=0, and immediately on its assertion, the following SHALL hold:
- pointers 0, usage_o=0, beat_idx_o=0, valid_o=0, shim_rdy_o=1;
- data_o, user_o, id_o, last_o, exokay_o SHALL be 0 (storage not cleared; outputs gated).
REQ-032 Reset asserted mid-burst SHALL discard all buffered beats with no partial output afterward.

Configuration
REQ-033 Macro AXI_RD_RESP_BUFFER_FALLTHROUGH_EN SHALL select fall-through behaviour.
- Defined: when usage_o=0 and shim_valid_i=1, valid_o SHALL assert combinationally with the input fields in the same cycle.
- Defined: if rdy_i=1 in that cycle, the beat is consumed without being stored, and usage_o stays 0.
- Undefined: REQ-029 latency applies and there is no combinational path from the shim_* inputs to the consumer outputs.

Verification
REQ-034 The bench SHALL cover these scenarios:
- Single beat: push data=0xA5A5_A5A5_A5A5_A5A5, last=1, id=3, rdy_i=1 -> valid_o next cycle (same cycle with macro), data/id match, beat_idx_o=0, usage_o back to 0.
- Fill: rdy_i=0, push 4 beats -> usage_o=4, shim_rdy_o=0 after the 4th; a 5th shim_valid_i is not accepted.
- Drain order: after fill with data 1,2,3,4 and last on beat 4, rdy_i=1 -> outputs 1,2,3,4 with beat_idx_o 0,1,2,3; beat_idx_o=0 after the last pop.
- Simultaneous push/pop at usage_o=2 for 10 cycles -> usage_o constant 2, pointers wrap, order preserved.
- Full plus pop: usage_o=4, rdy_i=1, shim_valid_i=1 -> no push that cycle; usage_o=3 next cycle; push occurs the cycle after.
- Reset mid-burst: 2 beats buffered, rst_ni=0 for 1 cycle -> valid_o=0, usage_o=0, beat_idx_o=0, shim_rdy_o=1 immediately.
